// File: rtl/fmul_ctrl_pkg.sv
// Shared types and defaults for the FP multiplier issue controller.
// Optional perf counters in the top are enabled with FMUL_PERF_CNT_EN.
package fmul_ctrl_pkg;

  localparam int FMUL_LAT_DEF    = 3;
  localparam int FMUL_ADDR_W_DEF = 5;

  typedef struct packed {
    logic [FMUL_ADDR_W_DEF-1:0] rd;
    logic                       fp_we;
  } fmul_tag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fmul_state_e;

  function automatic logic [31:0] fmul_popcnt(input logic [31:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/fmul_tag_pipe.sv
// LAT-deep valid+tag shift register shadowing the multiplier stages.
// Invalid stages always carry an all-zero tag so downstream masking stays trivial.
module fmul_tag_pipe
  import fmul_ctrl_pkg::*;
#(
  parameter int  LAT   = FMUL_LAT_DEF,
  parameter type tag_t = fmul_tag_t
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv_i,
  input  logic           flush_i,
  input  logic           load_i,
  input  tag_t           load_tag_i,
  output logic [LAT-1:0] vld_o,
  output logic [LAT-1:0] vld_nxt_o,
  output tag_t [LAT-1:0] tag_o
);

  logic [LAT-1:0] vld_q, vld_d;
  tag_t [LAT-1:0] tag_q, tag_d;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (flush_i) begin
      vld_d = '0;
      tag_d = '0;
    end else if (adv_i) begin
      for (int s = LAT-1; s >= 1; s--) begin
        vld_d[s] = vld_q[s-1];
        tag_d[s] = tag_q[s-1];
      end
      vld_d[0] = load_i;
      tag_d[0] = load_i ? load_tag_i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign vld_o     = vld_q;
  assign vld_nxt_o = vld_d;
  assign tag_o     = tag_q;

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Issue/retire sequencing for the pipelined FP multiplier: handshake, hold, flush.
// Define FMUL_PERF_CNT_EN to add the perf_issued/perf_hold/perf_flushed counters.
module fmul_issue_ctrl
  import fmul_ctrl_pkg::*;
#(
  parameter int LAT    = FMUL_LAT_DEF,
  parameter int ADDR_W = FMUL_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_rd,
  input  logic                  req_fp_we,
  input  logic                  flush,
  output logic                  mul_en,
  output logic [LAT-1:0]        mul_clear,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_W-1:0]     wb_rd,
  output logic                  wb_fp_we,
  output logic [LAT-1:0]        pend_valid,
  output logic [LAT*ADDR_W-1:0] pend_rd,
  output logic                  busy
`ifdef FMUL_PERF_CNT_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_hold,
  output logic [31:0]           perf_flushed
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              fp_we;
  } tag_t;

  logic           live_q;
  logic [LAT-1:0] vld, vld_nxt;
  tag_t [LAT-1:0] tag;
  tag_t           req_tag;
  logic           hold, advance, issue;
  fmul_state_e    state_q, state_d;

  // live keeps the handshake closed for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  assign hold      = vld[LAT-1] & ~wb_ready;
  assign advance   = live_q & ~hold;
  assign req_ready = advance & ~flush;
  assign issue     = req_valid & req_ready;
  // flush must reach the datapath even while frozen by writeback
  assign mul_en    = advance | (flush & rst_n);
  assign mul_clear = {LAT{flush | ~rst_n}};

  assign req_tag.rd    = req_rd;
  assign req_tag.fp_we = req_fp_we;

  fmul_tag_pipe #(.LAT(LAT), .tag_t(tag_t)) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (advance),
    .flush_i    (flush),
    .load_i     (issue),
    .load_tag_i (req_tag),
    .vld_o      (vld),
    .vld_nxt_o  (vld_nxt),
    .tag_o      (tag)
  );

  assign wb_valid = vld[LAT-1] & ~flush;
  assign wb_rd    = tag[LAT-1].rd;
  assign wb_fp_we = tag[LAT-1].fp_we;

  always_comb begin
    pend_valid = vld;
    pend_rd    = '0;
    for (int s = 0; s < LAT; s++)
      pend_rd[s*ADDR_W +: ADDR_W] = vld[s] ? tag[s].rd : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue) state_d = RUN;
      RUN: begin
        if (flush)         state_d = IDLE;
        else if (hold)     state_d = HOLD;
        else if (~|vld_nxt) state_d = IDLE;
      end
      HOLD: begin
        if (flush)         state_d = IDLE;
        else if (wb_ready) state_d = (|vld_nxt) ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

`ifdef FMUL_PERF_CNT_EN
  logic [31:0] issued_q, hold_q, flushed_q;

  // hold counts frozen cycles; a flush cycle unfreezes, so it is not counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q  <= '0;
      hold_q    <= '0;
      flushed_q <= '0;
    end else begin
      if (issue)          issued_q  <= issued_q + 32'd1;
      if (hold && !flush) hold_q    <= hold_q + 32'd1;
      if (flush)          flushed_q <= flushed_q + fmul_popcnt(32'(vld));
    end
  end

  assign perf_issued  = issued_q;
  assign perf_hold    = hold_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Self-checking bench: directed vector table, flush/reset sequences, random traffic vs. an op-list model.
module tb_fmul_issue_ctrl;

  localparam int LAT = 3;
  localparam int AW  = 5;

  logic              clk;
  logic              rst_n;
  logic              req_valid, req_ready, req_fp_we, flush;
  logic [AW-1:0]     req_rd;
  logic              mul_en, wb_valid, wb_ready, wb_fp_we, busy;
  logic [LAT-1:0]    mul_clear, pend_valid;
  logic [AW-1:0]     wb_rd;
  logic [LAT*AW-1:0] pend_rd;
`ifdef FMUL_PERF_CNT_EN
  logic [31:0]       perf_issued, perf_hold, perf_flushed;
`endif

  fmul_issue_ctrl #(.LAT(LAT), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rd     (req_rd),
    .req_fp_we  (req_fp_we),
    .flush      (flush),
    .mul_en     (mul_en),
    .mul_clear  (mul_clear),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_fp_we   (wb_fp_we),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd),
    .busy       (busy)
`ifdef FMUL_PERF_CNT_EN
    ,
    .perf_issued  (perf_issued),
    .perf_hold    (perf_hold),
    .perf_flushed (perf_flushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of in-flight ops, each knowing how many stages deep it is.
  typedef struct {
    logic [AW-1:0] rd;
    logic          fwe;
    int            stg;
  } op_t;
  op_t q[$];
  bit  live_m;
  bit  adv_m, rdy_m;

  task automatic check_model();
    bit             has_out;
    logic [AW-1:0]  ord;
    logic           ofwe;
    logic [LAT-1:0] pv;
    logic [LAT*AW-1:0] prd;
    has_out = 0; ord = '0; ofwe = 0; pv = '0; prd = '0;
    foreach (q[i]) begin
      pv[q[i].stg] = 1'b1;
      prd[q[i].stg*AW +: AW] = q[i].rd;
      if (q[i].stg == LAT-1) begin
        has_out = 1; ord = q[i].rd; ofwe = q[i].fwe;
      end
    end
    adv_m = live_m && !(has_out && !wb_ready);
    rdy_m = adv_m && !flush;
    chk("m_req_ready", 32'(req_ready), 32'(rdy_m));
    chk("m_mul_en",    32'(mul_en),    32'(adv_m || flush));
    chk("m_mul_clear", 32'(mul_clear), flush ? 32'((1 << LAT) - 1) : 32'd0);
    chk("m_wb_valid",  32'(wb_valid),  32'(has_out && !flush));
    if (has_out) chk("m_wb_tag", 32'({wb_rd, wb_fp_we}), 32'({ord, ofwe}));
    chk("m_pend_valid", 32'(pend_valid), 32'(pv));
    chk("m_pend_rd",    32'(pend_rd),    32'(prd));
    chk("m_busy",       32'(busy),       32'(q.size() != 0));
  endtask

  task automatic update_model();
    op_t nq[$];
    op_t n;
    if (!live_m) begin
      live_m = 1;
    end else if (flush) begin
      q.delete();
    end else if (adv_m) begin
      foreach (q[i]) if (q[i].stg != LAT-1) begin
        n = q[i]; n.stg = n.stg + 1; nq.push_back(n);
      end
      if (req_valid && rdy_m) begin
        n.rd = req_rd; n.fwe = req_fp_we; n.stg = 0; nq.push_back(n);
      end
      q = nq;
    end
  endtask

  task automatic set_in(input logic rv, input logic [AW-1:0] rd, input logic fwe,
                        input logic fl, input logic wbr);
    req_valid = rv; req_rd = rd; req_fp_we = fwe; flush = fl; wb_ready = wbr;
  endtask

  task automatic tick();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic step(input logic rv, input logic [AW-1:0] rd, input logic fwe,
                      input logic fl, input logic wbr);
    set_in(rv, rd, fwe, fl, wbr);
    @(negedge clk);
    check_model();
    tick();
  endtask

  // Release reset away from a clock edge; the cycle before live sets stays closed.
  task automatic release_reset();
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_model();
    chk("rel_req_ready", 32'(req_ready), 32'd0);
    chk("rel_mul_en",    32'(mul_en),    32'd0);
    tick();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_mul_en"},    32'(mul_en),    32'd0);
    chk({tag, "_mul_clear"}, 32'(mul_clear), 32'((1 << LAT) - 1));
    chk({tag, "_wb_valid"},  32'(wb_valid),  32'd0);
    chk({tag, "_wb_tag"},    32'({wb_rd, wb_fp_we}), 32'd0);
    chk({tag, "_pend"},      32'({pend_valid, pend_rd}), 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
  endtask

  typedef struct {
    logic rv; logic [AW-1:0] rd; logic fwe; logic wbr;
    logic rdy; logic en; logic wbv; logic [AW-1:0] wbrd; logic wbfwe;
    logic [LAT-1:0] pv; logic [LAT*AW-1:0] prd; logic busy;
  } vec_t;
  vec_t vecs[14];

  initial begin
    // single issue rd=5 walking to the output, then three back-to-back with a hold
    vecs[0]  = '{1'b1, 5'd5, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0,    1'b0};
    vecs[1]  = '{1'b0, 5'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b001, 15'd5,    1'b1};
    vecs[2]  = '{1'b0, 5'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b010, 15'd160,  1'b1};
    vecs[3]  = '{1'b0, 5'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 3'b100, 15'd5120, 1'b1};
    vecs[4]  = '{1'b0, 5'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0,    1'b0};
    vecs[5]  = '{1'b1, 5'd1, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0,    1'b0};
    vecs[6]  = '{1'b1, 5'd2, 1'b1, 1'b1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b001, 15'd1,    1'b1};
    vecs[7]  = '{1'b1, 5'd3, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b011, 15'd34,   1'b1};
    vecs[8]  = '{1'b0, 5'd0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 3'b111, 15'd1091, 1'b1};
    vecs[9]  = '{1'b1, 5'd9, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 3'b111, 15'd1091, 1'b1};
    vecs[10] = '{1'b0, 5'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 3'b111, 15'd1091, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 5'd2, 1'b1, 3'b110, 15'd2144, 1'b1};
    vecs[12] = '{1'b0, 5'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 3'b100, 15'd3072, 1'b1};
    vecs[13] = '{1'b0, 5'd0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 3'b000, 15'd0,    1'b0};

    rst_n = 1'b0;
    live_m = 0;
    set_in(0, '0, 0, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_outs("rst");
    release_reset();

    foreach (vecs[i]) begin
      set_in(vecs[i].rv, vecs[i].rd, vecs[i].fwe, 1'b0, vecs[i].wbr);
      @(negedge clk);
      check_model();
      chk("t_req_ready",  32'(req_ready),  32'(vecs[i].rdy));
      chk("t_mul_en",     32'(mul_en),     32'(vecs[i].en));
      chk("t_wb_valid",   32'(wb_valid),   32'(vecs[i].wbv));
      if (vecs[i].wbv) chk("t_wb_tag", 32'({wb_rd, wb_fp_we}), 32'({vecs[i].wbrd, vecs[i].wbfwe}));
      chk("t_pend_valid", 32'(pend_valid), 32'(vecs[i].pv));
      chk("t_pend_rd",    32'(pend_rd),    32'(vecs[i].prd));
      chk("t_busy",       32'(busy),       32'(vecs[i].busy));
      tick();
    end

    // flush with the oldest op sitting at the output
    step(1, 5'd11, 1, 0, 1);
    step(1, 5'd12, 0, 0, 1);
    step(1, 5'd13, 1, 0, 1);
    set_in(0, '0, 0, 1, 1);
    @(negedge clk);
    check_model();
    chk("fl_wb_valid",  32'(wb_valid),  32'd0);
    chk("fl_mul_clear", 32'(mul_clear), 32'd7);
    chk("fl_mul_en",    32'(mul_en),    32'd1);
    tick();
    set_in(0, '0, 0, 0, 1);
    @(negedge clk);
    chk("fl_after_pend", 32'(pend_valid), 32'd0);
    chk("fl_after_busy", 32'(busy), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) step(0, '0, 0, 0, 1);

    // flush while frozen by writeback back-pressure
    step(1, 5'd21, 1, 0, 1);
    step(1, 5'd22, 1, 0, 1);
    step(1, 5'd23, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    step(1, 5'd24, 0, 0, 0);
    set_in(0, '0, 0, 1, 0);
    @(negedge clk);
    check_model();
    chk("flh_mul_en",    32'(mul_en),    32'd1);
    chk("flh_mul_clear", 32'(mul_clear), 32'd7);
    chk("flh_wb_valid",  32'(wb_valid),  32'd0);
    tick();
    step(0, '0, 0, 0, 1);
    chk("flh_after_busy", 32'(busy), 32'd0);

    // reset mid-operation with two ops in flight
    step(1, 5'd7, 1, 0, 1);
    step(1, 5'd8, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    q.delete();
    live_m = 0;
    @(posedge clk);
    #1;
    release_reset();
    for (int k = 0; k < 5; k++) step(0, '0, 0, 0, 1);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) < 7));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fmul_issue_ctrl.md
Name: fmul_issue_ctrl

Overview:
Sequencing controller for the pipelined FP multiplier in the RV32 execute stage.
- Gates issue of multiply ops with a valid/ready handshake.
- Tracks the destination tag of each in-flight op, stage by stage.
- Freezes the multiplier pipeline when writeback back-pressures.
- Kills all in-flight ops on a pipeline flush.
- Exports pending destinations to the hazard unit.

Parameters:
LAT, 3, multiplier pipeline depth in cycles from accepted operands to result (>=1)
ADDR_W, 5, register address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  1  decode presents an FMUL op
req_ready  out  1  controller accepts op this cycle
req_rd  in  ADDR_W  destination register
req_fp_we  in  1  write FP regfile (1) or integer regfile (0)
flush  in  1  kill all in-flight ops and block issue this cycle
mul_en  out  1  multiplier pipeline advance enable
mul_clear  out  LAT  per-stage clear to multiplier
wb_valid  out  1  result at multiplier output is valid
wb_ready  in  1  writeback consumes result
wb_rd  out  ADDR_W  tag of output-stage op
wb_fp_we  out  1  tag of output-stage op
pend_valid  out  LAT  per-stage occupancy, index 0 = youngest
pend_rd  out  LAT*ADDR_W  per-stage destination, packed, stage i at [i*ADDR_W +: ADDR_W]
busy  out  1  any stage occupied

Behaviour:
- State: stage-valid vector v[LAT-1:0] and per-stage tags {rd, fp_we}; one-bit live flag; FSM state.
- Reset (async, rst_n low):
  - v, tags and live cleared.
  - req_ready=0, mul_en=0, mul_clear=all ones, wb_valid=0, wb_rd=0, wb_fp_we=0, busy=0, pend_*=0.
- live sets on the first clk edge after rst_n rises. req_ready and mul_en stay 0 until live=1.
- hold = v[LAT-1] & ~wb_ready.
- advance = live & ~hold.
- mul_en = advance | flush, so a flush always clears stages even during a hold.
- req_ready = advance & ~flush. An op issues when req_valid & req_ready.
- On advance without flush:
  - v and tags shift one stage toward LAT-1.
  - Stage 0 loads the issued op's tag, or v[0]=0 if nothing issued.
  - The output stage retires in the same cycle it handshakes.
- On hold: v and tags frozen; wb_* outputs stable until wb_ready.
- wb_valid = v[LAT-1] & ~flush. wb_rd and wb_fp_we are driven from the output-stage tag.
- flush:
  - Highest priority. mul_clear = all ones that cycle.
  - All v cleared on the next edge; no issue that cycle.
  - An output-stage op in the flush cycle is dropped, with wb_valid=0.
- mul_clear = 0 outside flush and reset.
- Latency: op issued at edge t gives wb_valid after edge t+LAT-1, plus the number of hold cycles. Back-to-back issue sustains 1 op/cycle when wb_ready=1.
- FSM states:
  - IDLE: v==0. Goes to RUN on issue.
  - RUN: ops in flight, no hold. Goes to HOLD when hold=1; to IDLE when v becomes 0 or on flush.
  - HOLD: frozen. Goes to RUN on wb_ready; to IDLE on flush.
  - busy = (state != IDLE).
- Simultaneous issue and retire in the same cycle is legal; occupancy stays unchanged.
- Reset mid-operation discards all in-flight ops; no wb_valid until new ops issue.

Optional Feature:
FMUL_PERF_CNT_EN
- Defined: adds outputs perf_issued[31:0] (increments per issue), perf_hold[31:0] (increments per HOLD cycle) and perf_flushed[31:0] (adds popcount(v) on flush).
  - All three counters reset to 0 and wrap at 2^32.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fmul_ctrl_pkg:
  - fmul_tag_t struct {rd[ADDR_W], fp_we}.
  - fmul_state_e enum {IDLE, RUN, HOLD}.
  - Default LAT constant.
- Sub-module fmul_tag_pipe: a LAT-deep shift register of valid+fmul_tag_t with advance, flush and load inputs; drives pend_* and the output tag.
- The FSM and handshake logic stay in fmul_issue_ctrl.

Test Plan:
- Reset release: rst_n low 2 cycles, then high → all outputs 0 while low; req_ready=1 from the second cycle after release.
- LAT=3, wb_ready=1, issue rd=5 fp_we=1 at edge t → wb_valid=1 with wb_rd=5, wb_fp_we=1 after edge t+2. pend_valid walks 001→010→100.
- Issue rd=1,2,3 back-to-back, wb_ready=0 when rd=1 reaches output → mul_en=0, req_ready=0, state HOLD, wb_rd=1 stable. After wb_ready=1, results retire in order 1,2,3 on consecutive cycles.
- Flush with 3 ops in flight, one at output → wb_valid=0 that cycle, mul_clear=3'b111, v=0 and state IDLE next cycle; no later wb_valid.
- Flush during HOLD → mul_en=1 and mul_clear=111 that cycle, IDLE next cycle. With FMUL_PERF_CNT_EN: perf_flushed grows by 3, perf_hold equals the held cycles.
- Assert rst_n low with 2 ops in flight → outputs clear immediately (async); no stale wb_valid after release.
